// File: rtl/gray_stream_pkg.sv
// rtl/gray_stream_pkg.sv - shared types and helpers for the gray frame streamer
// Purpose: FSM state encoding, pixel width and read-address width helper
//          shared by the streamer interface and the streamer itself.
// Ports: none (package).
package gray_stream_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  // Frame-buffer address width; never narrower than one bit.
  function automatic int addr_w(input int width, input int height);
    int n;
    n = $clog2(width * height);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/gray_frame_streamer_if.sv
// rtl/gray_frame_streamer_if.sv - frame-buffer read port and pixel stream bundle
// Purpose: groups the synchronous frame-buffer read port and the gray pixel
//          stream produced by the streamer.
// Signals:
//   mem_rd_en    read strobe (streamer -> frame buffer)
//   mem_rd_addr  read address (streamer -> frame buffer)
//   mem_rd_data  read data, valid the cycle after mem_rd_en (frame buffer -> streamer)
//   gray_valid   pixel strobe (streamer -> consumer)
//   gray         pixel value (streamer -> consumer)
//   sof          first pixel of the frame (streamer -> consumer)
//   eol          last pixel of each row (streamer -> consumer)
// Modports: master = streamer side, slave = frame buffer / consumer side.
interface gray_frame_streamer_if #(
  parameter int ADDR_W = 17
);
  import gray_stream_pkg::*;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [PIX_W-1:0]  mem_rd_data;
  logic              gray_valid;
  logic [PIX_W-1:0]  gray;
  logic              sof;
  logic              eol;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output gray_valid,
    output gray,
    output sof,
    output eol
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  gray_valid,
    input  gray,
    input  sof,
    input  eol
  );

endinterface

// File: rtl/gray_frame_streamer.sv
// rtl/gray_frame_streamer.sv - raster pixel source reading one frame from a frame buffer
// Purpose: on start, reads an IMAGE_WIDTH x IMAGE_HEIGHT 8-bit frame in row-major
//          order from a synchronous read port and emits it as a gray_valid/gray
//          stream tagged with sof/eol, optionally with H_BLANK idle cycles
//          between rows.
// Configuration: GRAY_STREAM_HBLANK_EN - when defined, the HBLANK state and its
//          counter are built and rows are separated by H_BLANK idle cycles;
//          when undefined, rows stream back-to-back and H_BLANK is ignored.
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   start  frame request, only honoured in IDLE
//   busy   high while a frame is in progress
//   done   one-cycle pulse when the last pixel has left
//   fb     gray_frame_streamer_if.master (frame-buffer read port + pixel stream)
module gray_frame_streamer
  import gray_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int H_BLANK      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  gray_frame_streamer_if.master  fb
);

  localparam int ADDR_W = addr_w(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int COL_W  = $clog2(IMAGE_WIDTH);
  localparam int ROW_W  = $clog2(IMAGE_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;

  // Read-stage strobe and the tags that travel with it down the pipe.
  logic rd_en;
  logic sof_rd;
  logic eol_rd;

  // Stage 1: read data arriving from the frame buffer.
  logic v1_q, sof1_q, eol1_q;
  // Stage 2: registered pixel on the output.
  logic              v2_q, sof2_q, eol2_q;
  logic [PIX_W-1:0]  gray_q;

`ifdef GRAY_STREAM_HBLANK_EN
  localparam int HB_W = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'((H_BLANK > 0) ? (H_BLANK - 1) : 0);

  logic [HB_W-1:0] hb_q, hb_d;
`endif

  assign rd_en  = (state_q == ST_ACTIVE);
  // Address 0 is only ever read as the very first pixel of a frame.
  assign sof_rd = rd_en && (addr_q == '0);
  assign eol_rd = rd_en && (col_q == COL_LAST);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
`ifdef GRAY_STREAM_HBLANK_EN
    hb_d    = hb_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACTIVE;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end

      ST_ACTIVE: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            // Address stays on the last pixel; it is reloaded on the next start.
            state_d = ST_FLUSH;
          end else begin
            // Row and address advance now; a blanking gap does not read,
            // so advancing early is not observable.
            row_d  = row_q + 1'b1;
            addr_d = addr_q + 1'b1;
`ifdef GRAY_STREAM_HBLANK_EN
            if (H_BLANK > 0) begin
              state_d = ST_HBLANK;
              hb_d    = '0;
            end
`endif
          end
        end else begin
          col_d  = col_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end

`ifdef GRAY_STREAM_HBLANK_EN
      ST_HBLANK: begin
        if (hb_q == HB_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          hb_d = hb_q + 1'b1;
        end
      end
`endif

      ST_FLUSH: begin
        // Once stage 1 is empty the final pixel is on the output this cycle,
        // so done lands on the cycle right after it.
        if (!v1_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

`ifdef GRAY_STREAM_HBLANK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_q <= '0;
    end else begin
      hb_q <= hb_d;
    end
  end
`endif

  // Two-stage valid pipe matching the one-cycle read latency plus the
  // output register; clearing it on reset drops any in-flight pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      sof1_q <= 1'b0;
      eol1_q <= 1'b0;
      v2_q   <= 1'b0;
      sof2_q <= 1'b0;
      eol2_q <= 1'b0;
      gray_q <= '0;
    end else begin
      v1_q   <= rd_en;
      sof1_q <= sof_rd;
      eol1_q <= eol_rd;
      v2_q   <= v1_q;
      sof2_q <= sof1_q;
      eol2_q <= eol1_q;
      if (v1_q) begin
        gray_q <= fb.mem_rd_data;
      end
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign fb.mem_rd_en   = rd_en;
  assign fb.mem_rd_addr = addr_q;
  assign fb.gray_valid  = v2_q;
  assign fb.gray        = gray_q;
  assign fb.sof         = sof2_q;
  assign fb.eol         = eol2_q;

endmodule

// File: tb/tb_gray_frame_streamer.sv
// tb/tb_gray_frame_streamer.sv - self-checking bench for gray_frame_streamer
module tb_gray_frame_streamer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 3;
`ifdef GRAY_STREAM_HBLANK_EN
  localparam int HB_EFF = HB;
`else
  localparam int HB_EFF = 0;
`endif
  localparam int P  = W + HB_EFF;           // row period in cycles
  localparam int L  = (H - 1) * P + W - 1;  // offset of the last read
  localparam int NV = L + 5;                // offsets 0 .. done+1

  // Packed view: {gray_valid, gray, sof, eol, busy, done, mem_rd_en, mem_rd_addr}
  typedef struct {
    int          off;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl [NV];

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_frame_streamer_if #(.ADDR_W(5)) bus ();

  gray_frame_streamer #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .H_BLANK     (HB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .fb   (bus)
  );

  // Synchronous frame buffer holding memory[a] = a.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= 8'(bus.mem_rd_addr);
    else               bus.mem_rd_data <= 8'hAA;
  end

  // Raster address read at frame offset d, or -1 if no read happens then.
  function automatic int slot_addr(int d);
    if (d < 0) return -1;
    if ((d / P) < H && (d % P) < W) return (d / P) * W + (d % P);
    return -1;
  endfunction

  function automatic logic [18:0] model(int d);
    int   ra = slot_addr(d);
    int   pa = slot_addr(d - 2);
    logic v  = (pa >= 0);
    return {v, v ? 8'(pa) : 8'h00, (pa == 0), v && ((pa % W) == W - 1),
            (d <= L + 2), (d == L + 3), (ra >= 0), (ra >= 0) ? 5'(ra) : 5'd0};
  endfunction

  function automatic logic [18:0] observe();
    return {bus.gray_valid, bus.gray_valid ? bus.gray : 8'h00, bus.sof, bus.eol,
            busy, done, bus.mem_rd_en, bus.mem_rd_en ? bus.mem_rd_addr : 5'd0};
  endfunction

  function automatic logic [18:0] observe_raw();
    return {bus.gray_valid, bus.gray, bus.sof, bus.eol,
            busy, done, bus.mem_rd_en, bus.mem_rd_addr};
  endfunction

  task automatic check(string name, logic [18:0] act, logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compares table rows first..last, one per cycle; start drops after row drop_at.
  task automatic run_frame(string tag, int first, int last, int drop_at);
    for (int i = first; i <= last; i++) begin
      check($sformatf("%s[%0d]", tag, tbl[i].off), observe(), tbl[i].exp);
      if (i == drop_at) start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int seen;

    for (int i = 0; i < NV; i++) tbl[i] = '{i, model(i)};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", observe_raw(), 19'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_no_start", observe_raw(), 19'd0);

    // Frame 1: single-cycle start pulse.
    start = 1'b1;
    @(negedge clk);
    run_frame("f1", 0, NV - 1, 0);

    // Frame 2: start held high; it must be ignored mid-frame and while
    // done is being produced, then accepted on the following edge.
    start = 1'b1;
    @(negedge clk);
    run_frame("f2", 0, L + 3, -1);
    check("restart_after_done", observe(), {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0});
    start = 1'b0;
    @(negedge clk);

    // Frame 3 (started above) gets reset in the middle of row 1.
    run_frame("f3", 1, 13, -1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_frame_reset", observe_raw(), 19'd0);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.gray_valid || bus.mem_rd_en || busy || done || bus.sof || bus.eol) seen++;
    end
    check("quiet_after_reset", 19'(seen), 19'd0);

    // Frame 4: fresh frame from pixel 0; start still high on the edge that
    // raises done and dropped before the next one, so no restart follows.
    start = 1'b1;
    @(negedge clk);
    run_frame("f4", 0, NV - 1, L + 3);
    check("idle_after_f4", observe(), 19'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_frame_streamer.md
# gray_frame_streamer

Raster pixel source for the grayscale filter chain. On `start`, it reads one IMAGE_WIDTH×IMAGE_HEIGHT 8-bit frame from a synchronous frame-buffer read port in row-major order. It emits the pixels as a `gray_valid`/`gray` stream with optional horizontal blanking between rows. It is the producer that drives the `gray_valid`/`gray` input of the median and other window filters.

## Interface
- IMAGE_WIDTH, 320, pixels per row (≥2)
- IMAGE_HEIGHT, 240, rows per frame (≥2)
- H_BLANK, 4, idle cycles inserted after each row except the last (0 allowed)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  frame request, sampled only in IDLE
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse, frame finished
- mem_rd_en  out  1  frame-buffer read strobe
- mem_rd_addr  out  ADDR_W  read address, ADDR_W = clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
- mem_rd_data  in  8  read data, valid the cycle after `mem_rd_en`
- gray_valid  out  1  pixel strobe
- gray  out  8  pixel value
- sof  out  1  high with the first pixel of the frame
- eol  out  1  high with the last pixel of each row

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, FLUSH.
- IDLE:
  - `start`=1 → ACTIVE; col=0, row=0, addr=0.
  - `start` in any other state is ignored.
- ACTIVE:
  - `mem_rd_en`=1 every cycle; address increments by 1; col counts 0..IMAGE_WIDTH-1.
  - At col=IMAGE_WIDTH-1:
    - last row → FLUSH;
    - else if H_BLANK>0 → HBLANK;
    - else stay in ACTIVE with col=0, row+1.
- HBLANK: `mem_rd_en`=0 for exactly H_BLANK cycles, then ACTIVE with col=0, row+1.
- FLUSH: wait for the last pixel to leave the pipe, pulse `done`, then go to IDLE.
- Output pipe: a 2-stage valid shift (rd_en → data-valid → `gray_valid`) carries the sof/eol tags alongside it. `gray` registers `mem_rd_data`.
- Address never exceeds IMAGE_WIDTH*IMAGE_HEIGHT-1. The counters wrap to 0 on a new frame; no other wrap occurs.
- `gray_valid` pulses per frame = IMAGE_WIDTH*IMAGE_HEIGHT exactly; `sof` pulses once; `eol` pulses IMAGE_HEIGHT times.

## Timing
- Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, gray_valid=0, gray=0, sof=0, eol=0, FSM=IDLE, pipe valids cleared.
- `start` sampled at edge k → `mem_rd_en`=1 and `busy`=1 from edge k. First `gray_valid` at edge k+2.
- Read-to-pixel latency: 2 cycles.
- Throughput: 1 pixel/clk within a row. Row period = IMAGE_WIDTH+H_BLANK cycles.
- `done` asserts the cycle after the final `gray_valid`; `busy` drops with it.
- A `start` in the same cycle as `done` is ignored (FSM not yet IDLE). The earliest accepted `start` is the cycle after `done`.
- `rst` mid-frame: all outputs return to reset values at the next edge. No in-flight pixel is emitted after reset deasserts.

## Configuration
- `GRAY_STREAM_HBLANK_EN`
  - Defined: HBLANK state and H_BLANK counter are present; blanking occurs as above.
  - Undefined: HBLANK state and counter are compiled out; H_BLANK is ignored; rows stream back-to-back (frame = W*H consecutive `gray_valid` cycles).

## Structure
- Shared package `gray_stream_pkg`: FSM state enum, `PIX_W`=8, ADDR_W helper function.
- Single module; no sub-module. Counter and FSM logic are small enough to stay inline.

## Test plan
- IMAGE_WIDTH=8, IMAGE_HEIGHT=4, H_BLANK=3, macro defined, memory[a]=a:
  - `start` at edge 10 → `gray_valid` edges 12..19, 23..30, 34..41, 45..52; `gray`=0..31 in order.
  - Same config → `sof` only with gray=0; `eol` with 7, 15, 23, 31; `done` at edge 53; `busy` high edges 10..52.
- `start` held high continuously → second frame's first `mem_rd_en` at edge 54; no read issued between edges 44 and 53 beyond address 31.
- `rst` asserted at edge 20 (mid row 1) for 1 cycle → all outputs 0 from edge 21; no `gray_valid` until a new `start`; the next frame begins at gray=0.
- Macro undefined, same params → `gray_valid` continuous for 32 cycles (edges 12..43); `done` at 44.
- IMAGE_WIDTH=7, IMAGE_HEIGHT=7 feeding median7x7 with a constant 100 frame → exactly one `median_valid`, `median_out`=100.
